// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle MIPS main FSM and its datapath.
// The control FSM is the master; the datapath supplies Opcode/Zero.
interface mips_multicycle_control_if;
  logic [5:0] Opcode;
  logic       Zero;
  logic [3:0] ALUOpSignal;
  logic       PCWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic       IllegalOp;
  logic       InstrDone;
  logic [3:0] State;

  modport master (
    input  Opcode, Zero,
    output ALUOpSignal, PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, IllegalOp, InstrDone, State
  );

  modport slave (
    output Opcode, Zero,
    input  ALUOpSignal, PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, IllegalOp, InstrDone, State
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback and drives all datapath enables plus the 4-bit ALU op code.
module mips_multicycle_control #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  mips_multicycle_control_if.master         bus
);

  localparam int unsigned OP_W = 6;
  localparam int unsigned ST_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'b001011;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  typedef enum logic [ST_W-1:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEXEC = 4'd6,
    RTWB   = 4'd7,
    BRANCH = 4'd8,
    IEXEC  = 4'd9,
    IWB    = 4'd10,
    JUMP   = 4'd11,
    HALT   = 4'd15
  } state_t;

  state_t          state_q, state_d;
  logic [OP_W-1:0] op_q;

  // State register; opcode is captured once in DECODE so later states ignore IR changes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= bus.Opcode;
    end
  end

  always_comb begin
    state_d         = state_q;
    bus.ALUOpSignal = 4'b0000;
    bus.PCWrite     = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.PCSource    = 2'b00;
    bus.IllegalOp   = 1'b0;
    bus.InstrDone   = 1'b0;
    bus.State       = ST_W'(state_q);

    case (state_q)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.IRWrite = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.PCWrite = 1'b1;
        state_d     = DECODE;
      end
      DECODE: begin
        bus.ALUSrcB = 2'b11;
        case (bus.Opcode)
          OP_LW, OP_SW:                                  state_d = MEMADR;
          OP_RTYPE:                                      state_d = RTEXEC;
          OP_BEQ, OP_BNE:                                state_d = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_SLTIU:   state_d = IEXEC;
          OP_J:                                          state_d = JUMP;
          default: begin
            bus.IllegalOp = 1'b1;
            state_d       = ILLEGAL_TRAP ? HALT : FETCH;
          end
        endcase
      end
      MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = (op_q == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        state_d     = MEMWB;
      end
      MEMWB: begin
        bus.RegWrite  = 1'b1;
        bus.MemtoReg  = 1'b1;
        bus.InstrDone = 1'b1;
        state_d       = FETCH;
      end
      MEMWR: begin
        bus.MemWrite  = 1'b1;
        bus.IorD      = 1'b1;
        bus.InstrDone = 1'b1;
        state_d       = FETCH;
      end
      RTEXEC: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOpSignal = 4'b0010;
        state_d         = RTWB;
      end
      RTWB: begin
        bus.RegWrite  = 1'b1;
        bus.RegDst    = 1'b1;
        bus.InstrDone = 1'b1;
        state_d       = FETCH;
      end
      BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOpSignal = 4'b0001;
        bus.PCSource    = 2'b01;
        bus.PCWrite     = (op_q == OP_BNE) ? ~bus.Zero : bus.Zero;
        bus.InstrDone   = 1'b1;
        state_d         = FETCH;
      end
      IEXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        case (op_q)
          OP_ADDI:            bus.ALUOpSignal = 4'b0011;
          OP_ANDI:            bus.ALUOpSignal = 4'b0100;
          OP_ORI:             bus.ALUOpSignal = 4'b0101;
          OP_SLTI, OP_SLTIU:  bus.ALUOpSignal = 4'b0110;
          default:            bus.ALUOpSignal = 4'b0000;
        endcase
        state_d = IWB;
      end
      IWB: begin
        bus.RegWrite  = 1'b1;
        bus.InstrDone = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        bus.PCSource  = 2'b10;
        bus.PCWrite   = 1'b1;
        bus.InstrDone = 1'b1;
        state_d       = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase

    // While reset is asserted, suppress every write/strobe and present FETCH steering.
    if (!rst_n) begin
      bus.ALUOpSignal = 4'b0000;
      bus.PCWrite     = 1'b0;
      bus.IorD        = 1'b0;
      bus.MemRead     = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.MemtoReg    = 1'b0;
      bus.RegDst      = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.ALUSrcA     = 1'b0;
      bus.ALUSrcB     = 2'b01;
      bus.PCSource    = 2'b00;
      bus.IllegalOp   = 1'b0;
      bus.InstrDone   = 1'b0;
      bus.State       = ST_W'(FETCH);
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multicycle MIPS control FSM; runs both illegal-opcode policies side by side.
module tb_mips_multicycle_control;

  logic clk = 1'b0;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;

  mips_multicycle_control_if ifa ();
  mips_multicycle_control_if ifb ();

  assign ifb.Opcode = ifa.Opcode;
  assign ifb.Zero   = ifa.Zero;

  mips_multicycle_control #(.ILLEGAL_TRAP(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  mips_multicycle_control #(.ILLEGAL_TRAP(1'b1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  always #5 clk = ~clk;

  // {PCWrite, MemWrite, RegWrite, IRWrite, MemRead, IllegalOp, InstrDone}
  logic [6:0] en_a, en_b;
  assign en_a = {ifa.PCWrite, ifa.MemWrite, ifa.RegWrite, ifa.IRWrite, ifa.MemRead, ifa.IllegalOp, ifa.InstrDone};
  assign en_b = {ifb.PCWrite, ifb.MemWrite, ifb.RegWrite, ifb.IRWrite, ifb.MemRead, ifb.IllegalOp, ifb.InstrDone};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; sampling happens 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    ifa.Opcode = 6'b000000;
    ifa.Zero   = 1'b0;

    // Reset held two cycles
    tick(); tick();
    check("rst_state_a", 8'(ifa.State), 8'd0);
    check("rst_state_b", 8'(ifb.State), 8'd0);
    check("rst_en_a",    8'(en_a), 8'h00);
    check("rst_alusrcb", 8'(ifa.ALUSrcB), 8'd1);

    rst_n = 1'b1;
    #1;
    check("post_rst_fetch_en", 8'(en_a), 8'b1001_100);
    check("post_rst_state",    8'(ifa.State), 8'd0);

    // lw: 0,1,2,3,4
    ifa.Opcode = 6'b100011;
    tick();
    check("lw_decode_state", 8'(ifa.State), 8'd1);
    check("lw_decode_srcb",  8'(ifa.ALUSrcB), 8'd3);
    check("lw_decode_done",  8'(ifa.InstrDone), 8'd0);
    tick();
    ifa.Opcode = 6'b000000;
    check("lw_memadr_state", 8'(ifa.State), 8'd2);
    check("lw_memadr_aluop", 8'(ifa.ALUOpSignal), 8'd0);
    check("lw_memadr_src",   8'({ifa.ALUSrcA, ifa.ALUSrcB}), 8'b110);
    tick();
    check("lw_memrd_state",  8'(ifa.State), 8'd3);
    check("lw_memrd_rd_iord", 8'({ifa.MemRead, ifa.IorD, ifa.InstrDone}), 8'b110);
    tick();
    check("lw_memwb_state",  8'(ifa.State), 8'd4);
    check("lw_memwb_en",     8'(en_a), 8'b0010_001);
    check("lw_memwb_m2r",    8'({ifa.MemtoReg, ifa.RegDst}), 8'b10);
    tick();
    check("lw_back_fetch",   8'(ifa.State), 8'd0);
    check("lw_fetch_nodone", 8'(ifa.InstrDone), 8'd0);

    // R-type
    ifa.Opcode = 6'b000000;
    tick(); tick();
    check("rt_exec_state", 8'(ifa.State), 8'd6);
    check("rt_exec_aluop", 8'(ifa.ALUOpSignal), 8'd2);
    check("rt_exec_src",   8'({ifa.ALUSrcA, ifa.ALUSrcB}), 8'b100);
    tick();
    check("rt_wb_state",   8'(ifa.State), 8'd7);
    check("rt_wb_ctl",     8'({ifa.RegWrite, ifa.RegDst, ifa.MemtoReg, ifa.InstrDone}), 8'b1101);
    tick();
    check("rt_back_fetch", 8'(ifa.State), 8'd0);

    // ori
    ifa.Opcode = 6'b001101;
    tick(); tick();
    check("ori_exec_state", 8'(ifa.State), 8'd9);
    check("ori_exec_aluop", 8'(ifa.ALUOpSignal), 8'd5);
    check("ori_exec_srcb",  8'(ifa.ALUSrcB), 8'd2);
    tick();
    check("ori_wb_state",   8'(ifa.State), 8'd10);
    check("ori_wb_en",      8'(en_a), 8'b0010_001);
    tick();

    // beq with Zero=1 takes the branch
    ifa.Opcode = 6'b000100;
    ifa.Zero   = 1'b1;
    tick(); tick();
    check("beq_state",   8'(ifa.State), 8'd8);
    check("beq_pcwrite", 8'(ifa.PCWrite), 8'd1);
    check("beq_aluop",   8'(ifa.ALUOpSignal), 8'd1);
    check("beq_pcsrc",   8'(ifa.PCSource), 8'd1);
    tick();

    // bne with Zero=1 does not
    ifa.Opcode = 6'b000101;
    tick(); tick();
    check("bne_state",   8'(ifa.State), 8'd8);
    check("bne_pcwrite", 8'(ifa.PCWrite), 8'd0);
    check("bne_aluop",   8'(ifa.ALUOpSignal), 8'd1);
    check("bne_done",    8'(ifa.InstrDone), 8'd1);
    tick();

    // jump
    ifa.Opcode = 6'b000010;
    ifa.Zero   = 1'b0;
    tick(); tick();
    check("j_state", 8'(ifa.State), 8'd11);
    check("j_ctl",   8'({ifa.PCSource, ifa.PCWrite, ifa.InstrDone}), 8'b1011);
    tick();
    check("j_back_fetch", 8'(ifa.State), 8'd0);

    // Illegal opcode: both pulse IllegalOp, then diverge
    ifa.Opcode = 6'b111111;
    tick();
    check("ill_pulse_a", 8'(ifa.IllegalOp), 8'd1);
    check("ill_pulse_b", 8'(ifb.IllegalOp), 8'd1);
    tick();
    ifa.Opcode = 6'b000010;
    check("ill_a_fetch",   8'(ifa.State), 8'd0);
    check("ill_a_nopulse", 8'(ifa.IllegalOp), 8'd0);
    check("ill_b_halt",    8'(ifb.State), 8'd15);
    check("ill_b_en",      8'(en_b), 8'h00);
    tick(); tick();
    check("ill_b_hold",    8'(ifb.State), 8'd15);
    rst_n = 1'b0;
    tick();
    check("ill_b_rst",     8'(ifb.State), 8'd0);
    rst_n = 1'b1;
    #1;
    check("ill_b_refetch", 8'(en_b), 8'b1001_100);

    // sw aborted by reset in MEMWR
    ifa.Opcode = 6'b101011;
    tick(); tick();
    check("sw_memadr", 8'(ifa.State), 8'd2);
    tick();
    check("sw_memwr_state", 8'(ifa.State), 8'd5);
    check("sw_memwr_wr",    8'(ifa.MemWrite), 8'd1);
    rst_n = 1'b0;
    #1;
    check("sw_rst_nowrite", 8'(en_a), 8'h00);
    tick();
    rst_n = 1'b1;
    #1;
    check("sw_rst_state",   8'(ifa.State), 8'd0);
    check("sw_rst_fetch",   8'(en_a), 8'b1001_100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
